reg_wb_scheduler: RTL and testbench

REG_WB_SCHEDULER -- requirements
Module: reg_wb_scheduler

---
 rtl/reg_wb_scheduler_pkg.sv | 18 +
 rtl/reg_wb_scheduler_if.sv | 57 +++++
 rtl/reg_wb_scheduler_scoreboard.sv | 43 ++++
 rtl/reg_wb_scheduler.sv | 82 ++++++++
 tb/tb_reg_wb_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_scheduler_pkg.sv
// Shared types and defaults for the writeback scheduler slice.
// Holds register-index width and the writeback source encoding.
package reg_wb_scheduler_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int IDX_W    = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_t;

    function automatic logic is_x0(input logic [IDX_W-1:0] idx);
        return idx == '0;
    endfunction

endpackage

// File: rtl/reg_wb_scheduler_if.sv
// Writeback, issue, hazard-query and register-file write bundle.
// master drives writebacks/issues; slave is the scheduler.
interface reg_wb_scheduler_if
    import reg_wb_scheduler_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) ();

    logic             alu_valid;
    logic             alu_ready;
    logic [IDX_W-1:0] alu_dest;
    logic [XLEN-1:0]  alu_data;

    logic             lsu_valid;
    logic             lsu_ready;
    logic [IDX_W-1:0] lsu_dest;
    logic [XLEN-1:0]  lsu_data;

    logic             issue_valid;
    logic             issue_ready;
    logic [IDX_W-1:0] issue_dest;

    logic [IDX_W-1:0] query_src1;
    logic [IDX_W-1:0] query_src2;
    logic             src1_busy;
    logic             src2_busy;

    logic             reg_write;
    logic [IDX_W-1:0] dest;
    logic [XLEN-1:0]  write_data;
    logic [15:0]      commit_count;

    modport master (
        output alu_valid, alu_dest, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_dest, lsu_data,
        input  lsu_ready,
        output issue_valid, issue_dest,
        input  issue_ready,
        output query_src1, query_src2,
        input  src1_busy, src2_busy,
        input  reg_write, dest, write_data, commit_count
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_dest, lsu_data,
        output lsu_ready,
        input  issue_valid, issue_dest,
        output issue_ready,
        input  query_src1, query_src2,
        output src1_busy, src2_busy,
        output reg_write, dest, write_data, commit_count
    );

endinterface

// File: rtl/reg_wb_scheduler_scoreboard.sv
// Busy-bit scoreboard: issue reserves, commit releases, set wins.
// Bit 0 models x0 and never becomes busy.
module reg_scoreboard
    import reg_wb_scheduler_pkg::*;
#(
    parameter int NREG = NREG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [IDX_W-1:0] issue_dest,
    output logic             issue_ready,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] src1,
    input  logic [IDX_W-1:0] src2,
    output logic             src1_busy,
    output logic             src2_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            set_en;

    assign issue_ready = rst & ~busy_q[issue_dest];
    assign set_en      = issue_valid & issue_ready & ~is_x0(issue_dest);
    assign src1_busy   = busy_q[src1];
    assign src2_busy   = busy_q[src2];

    // Clear first so a same-edge reservation of the index survives.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[issue_dest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Round-robin ALU/LSU writeback arbiter with a registered commit port.
// Drives the register-file write port and the operand scoreboard.
module reg_wb_scheduler
    import reg_wb_scheduler_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    reg_wb_scheduler_if.slave bus
);

    src_t             last_grant;
    logic             grant_alu;
    logic             grant_lsu;
    logic             xfer_alu;
    logic             xfer;
    logic [IDX_W-1:0] sel_dest;
    logic [XLEN-1:0]  sel_data;

    logic             reg_write_q;
    logic [IDX_W-1:0] dest_q;
    logic [XLEN-1:0]  data_q;
    logic [15:0]      count_q;

    // On a tie the source not granted last wins.
    always_comb begin
        grant_alu = bus.alu_valid &
                    (~bus.lsu_valid | (last_grant == SRC_LSU));
        grant_lsu = bus.lsu_valid &
                    (~bus.alu_valid | (last_grant == SRC_ALU));
    end

    assign bus.alu_ready = rst & grant_alu;
    assign bus.lsu_ready = rst & grant_lsu;

    assign xfer_alu = bus.alu_valid & bus.alu_ready;
    assign xfer     = xfer_alu | (bus.lsu_valid & bus.lsu_ready);
    assign sel_dest = xfer_alu ? bus.alu_dest : bus.lsu_dest;
    assign sel_data = xfer_alu ? bus.alu_data : bus.lsu_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q <= 1'b0;
            dest_q      <= '0;
            data_q      <= '0;
            count_q     <= '0;
            last_grant  <= SRC_LSU;
        end else begin
            reg_write_q <= xfer & ~is_x0(sel_dest);
            if (xfer) begin
                dest_q     <= sel_dest;
                data_q     <= sel_data;
                count_q    <= count_q + 16'd1;
                last_grant <= xfer_alu ? SRC_ALU : SRC_LSU;
            end
        end
    end

    assign bus.reg_write    = reg_write_q;
    assign bus.dest         = dest_q;
    assign bus.write_data   = data_q;
    assign bus.commit_count = count_q;

    reg_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (bus.issue_valid),
        .issue_dest  (bus.issue_dest),
        .issue_ready (bus.issue_ready),
        .clr_en      (reg_write_q),
        .clr_idx     (dest_q),
        .src1        (bus.query_src1),
        .src2        (bus.query_src2),
        .src1_busy   (bus.src1_busy),
        .src2_busy   (bus.src2_busy)
    );

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench for reg_wb_scheduler with a commit expectation queue.
// Arbitration is modelled independently to predict grants and commits.
module tb_reg_wb_scheduler;
    import reg_wb_scheduler_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_wb_scheduler_if #(.XLEN(32)) bus ();

    reg_wb_scheduler #(
        .XLEN (32),
        .NREG (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        q[$];
    int          checks;
    int          errors;
    src_t        last_g;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
    logic [15:0] e_cnt;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0;
        bus.lsu_valid   = 1'b0;
        bus.issue_valid = 1'b0;
    endtask

    task automatic set_alu(input logic [4:0] d, input logic [31:0] v);
        bus.alu_valid = 1'b1;
        bus.alu_dest  = d;
        bus.alu_data  = v;
    endtask

    task automatic set_lsu(input logic [4:0] d, input logic [31:0] v);
        bus.lsu_valid = 1'b1;
        bus.lsu_dest  = d;
        bus.lsu_data  = v;
    endtask

    task automatic set_issue(input logic [4:0] d);
        bus.issue_valid = 1'b1;
        bus.issue_dest  = d;
    endtask

    // Before the edge: predict grants, push the expected commit.
    task automatic pre();
        logic ar;
        logic lr;
        exp_t e;
        #1;
        ar = bus.alu_valid && (!bus.lsu_valid || last_g == SRC_LSU);
        lr = bus.lsu_valid && (!bus.alu_valid || last_g == SRC_ALU);
        chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
        chk("lsu_ready", 32'(bus.lsu_ready), 32'(lr));
        if (ar) begin
            e.we = (bus.alu_dest != 5'd0);
            e.dest = bus.alu_dest;
            e.data = bus.alu_data;
            q.push_back(e);
            last_g = SRC_ALU;
        end else if (lr) begin
            e.we = (bus.lsu_dest != 5'd0);
            e.dest = bus.lsu_dest;
            e.data = bus.lsu_data;
            q.push_back(e);
            last_g = SRC_LSU;
        end
    endtask

    // After the edge: pop and compare the write port.
    task automatic post();
        exp_t e;
        logic we;
        @(posedge clk);
        #1;
        we = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            we = e.we;
            e_dest = e.dest;
            e_data = e.data;
            e_cnt = e_cnt + 16'd1;
        end
        chk("reg_write", 32'(bus.reg_write), 32'(we));
        chk("dest", 32'(bus.dest), 32'(e_dest));
        chk("write_data", bus.write_data, e_data);
        chk("commit_count", 32'(bus.commit_count), 32'(e_cnt));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        last_g = SRC_LSU;
        e_dest = '0;
        e_data = '0;
        e_cnt  = '0;
        rst = 1'b0;
        set_alu(5'd1, 32'h1);
        set_lsu(5'd2, 32'h2);
        set_issue(5'd5);
        bus.query_src1 = 5'd0;
        bus.query_src2 = 5'd0;
        #2;
        chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
        chk("rst_dest", 32'(bus.dest), 32'd0);
        chk("rst_data", bus.write_data, 32'd0);
        chk("rst_count", 32'(bus.commit_count), 32'd0);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        repeat (2) @(negedge clk);
        idle();
        rst = 1'b1;

        // ALU only
        set_alu(5'd5, 32'hDEADBEEF);
        pre();
        post();
        chk("alu_only_count", 32'(bus.commit_count), 32'd1);
        @(negedge clk);
        idle();
        pre();
        post();

        // LSU only, leaves LSU as last grant
        @(negedge clk);
        set_lsu(5'd2, 32'h22);
        pre();
        post();

        // Tie held four cycles
        @(negedge clk);
        set_alu(5'd3, 32'hAAAA0003);
        set_lsu(5'd4, 32'hBBBB0004);
        for (int i = 0; i < 4; i++) begin
            pre();
            chk("tie_grant_alu", 32'(bus.alu_ready), 32'((i % 2) == 0));
            post();
            chk("tie_dest", 32'(bus.dest), ((i % 2) == 0) ? 32'd3 : 32'd4);
            @(negedge clk);
        end
        idle();
        pre();
        post();

        // Scoreboard reserve / release
        @(negedge clk);
        set_issue(5'd7);
        bus.query_src1 = 5'd7;
        pre();
        chk("sb_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("sb_busy_before", 32'(bus.src1_busy), 32'd0);
        post();
        @(negedge clk);
        set_lsu(5'd7, 32'h77);
        pre();
        chk("sb_reissue_ready", 32'(bus.issue_ready), 32'd0);
        chk("sb_busy_set", 32'(bus.src1_busy), 32'd1);
        post();
        @(negedge clk);
        idle();
        pre();
        chk("sb_busy_commit_cycle", 32'(bus.src1_busy), 32'd1);
        post();
        @(negedge clk);
        pre();
        chk("sb_busy_cleared", 32'(bus.src1_busy), 32'd0);
        post();

        // Same-edge set and clear on x9
        @(negedge clk);
        set_alu(5'd9, 32'h99);
        bus.query_src1 = 5'd9;
        pre();
        post();
        @(negedge clk);
        idle();
        set_issue(5'd9);
        pre();
        chk("same_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("same_busy_before", 32'(bus.src1_busy), 32'd0);
        post();
        chk("same_busy_after", 32'(bus.src1_busy), 32'd1);
        @(negedge clk);
        idle();
        pre();
        chk("same_busy_hold", 32'(bus.src1_busy), 32'd1);
        post();

        // x0 handling
        @(negedge clk);
        set_issue(5'd0);
        bus.query_src2 = 5'd0;
        pre();
        chk("x0_issue_ready", 32'(bus.issue_ready), 32'd1);
        post();
        chk("x0_not_busy", 32'(bus.src2_busy), 32'd0);
        @(negedge clk);
        idle();
        set_alu(5'd0, 32'h1234);
        pre();
        post();
        chk("x0_busy9_kept", 32'(bus.src1_busy), 32'd1);
        @(negedge clk);
        idle();
        pre();
        post();
        chk("x0_busy9_after", 32'(bus.src1_busy), 32'd1);

        // Reset mid-stream with a pending commit
        @(negedge clk);
        set_alu(5'd11, 32'hBB);
        set_issue(5'd12);
        bus.query_src2 = 5'd12;
        pre();
        post();
        idle();
        set_alu(5'd3, 32'h33);
        set_lsu(5'd4, 32'h44);
        bus.issue_dest = 5'd12;
        chk("pre_rst_busy12", 32'(bus.src2_busy), 32'd1);
        chk("pre_rst_busy9", 32'(bus.src1_busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_reg_write", 32'(bus.reg_write), 32'd0);
        chk("mid_rst_dest", 32'(bus.dest), 32'd0);
        chk("mid_rst_data", bus.write_data, 32'd0);
        chk("mid_rst_count", 32'(bus.commit_count), 32'd0);
        chk("mid_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("mid_rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
        chk("mid_rst_issue_ready", 32'(bus.issue_ready), 32'd0);
        chk("mid_rst_busy9", 32'(bus.src1_busy), 32'd0);
        chk("mid_rst_busy12", 32'(bus.src2_busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_no_write", 32'(bus.reg_write), 32'd0);
        chk("rst_edge_count", 32'(bus.commit_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        last_g = SRC_LSU;
        e_dest = '0;
        e_data = '0;
        e_cnt = '0;
        pre();
        chk("post_rst_tie_alu", 32'(bus.alu_ready), 32'd1);
        post();
        @(negedge clk);
        idle();
        pre();
        post();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
